// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: data width, register-number width,
// ALU op-code constants and control-bit positions.
package execute_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 6;

  // ALU op codes (R-type funct or zero-extended immediate-form op)
  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
  localparam logic [OP_W-1:0] OP_AND   = 6'd2;
  localparam logic [OP_W-1:0] OP_OR    = 6'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 6'd5;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd6;
  localparam logic [OP_W-1:0] OP_PASSB = 6'd7;

  // Control bit positions
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;
  localparam int MEM_WRITE     = 1;
  localparam int MEM_READ      = 0;
  localparam int CC_RTYPE      = 3;

endpackage

// File: rtl/execute_if.sv
// Bundle of the execute stage's decode-side inputs, MEM/WB forwarding inputs
// and EX/MEM registered outputs. master = upstream driver, slave = execute.
interface execute_if;
  import execute_pkg::*;

  logic [1:0]        writeBackControlIn;
  logic [1:0]        memAccessControlIn;
  logic [3:0]        calculationControl;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] immediateOperand;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rdIn;
  logic              memWbRegWrite;
  logic [REG_W-1:0]  memWbRd;
  logic [DATA_W-1:0] memWbData;
  logic [1:0]        writeBackControlOut;
  logic [1:0]        memAccessControlOut;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] writeData;
  logic [REG_W-1:0]  rdOut;

  modport master (
    output writeBackControlIn, memAccessControlIn, calculationControl,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           memWbRegWrite, memWbRd, memWbData,
    input  writeBackControlOut, memAccessControlOut, result, writeData, rdOut
  );

  modport slave (
    input  writeBackControlIn, memAccessControlIn, calculationControl,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           memWbRegWrite, memWbRd, memWbData,
    output writeBackControlOut, memAccessControlOut, result, writeData, rdOut
  );

endinterface

// File: rtl/execute_alu.sv
// Combinational 32-bit ALU for the execute stage. Wrap-around arithmetic,
// no flags; undefined op codes produce zero.
module execute_alu
  import execute_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] aSigned;
  logic signed [DATA_W-1:0] bSigned;

  assign aSigned = a;
  assign bSigned = b;

  // Select the operation result
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~(a | b);
      OP_SLT:   y = {{(DATA_W-1){1'b0}}, (aSigned < bSigned)};
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// Execute pipeline stage: operand forwarding, ALU, EX/MEM output register.
// Optional feature macro: EXECUTE_FORWARD_EN enables EX/MEM and MEM/WB
// operand forwarding; without it readData1/readData2 are used directly.
module execute
  import execute_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  execute_if.slave ex
);

  logic              rType;
  logic [OP_W-1:0]   aluOp;
  logic [DATA_W-1:0] operandA;
  logic [DATA_W-1:0] rtValue;
  logic [DATA_W-1:0] operandB;
  logic [DATA_W-1:0] aluY;

  assign rType = ex.calculationControl[CC_RTYPE];
  assign aluOp = rType ? ex.immediateOperand[OP_W-1:0]
                       : {3'b000, ex.calculationControl[2:0]};

`ifdef EXECUTE_FORWARD_EN
  // EX/MEM beats MEM/WB; register 0 is never forwarded.
  function automatic logic [DATA_W-1:0] forwardSel(
    input logic [REG_W-1:0]  src,
    input logic [DATA_W-1:0] regData,
    input logic              exMemWrite,
    input logic [REG_W-1:0]  exMemRd,
    input logic [DATA_W-1:0] exMemData,
    input logic              wbWrite,
    input logic [REG_W-1:0]  wbRd,
    input logic [DATA_W-1:0] wbData
  );
    if (exMemWrite && (exMemRd == src) && (exMemRd != '0))
      return exMemData;
    else if (wbWrite && (wbRd == src) && (wbRd != '0))
      return wbData;
    else
      return regData;
  endfunction

  assign operandA = forwardSel(ex.rs, ex.readData1,
                               ex.writeBackControlOut[WB_REG_WRITE], ex.rdOut, ex.result,
                               ex.memWbRegWrite, ex.memWbRd, ex.memWbData);
  assign rtValue  = forwardSel(ex.rt, ex.readData2,
                               ex.writeBackControlOut[WB_REG_WRITE], ex.rdOut, ex.result,
                               ex.memWbRegWrite, ex.memWbRd, ex.memWbData);
`else
  logic unusedForwardInputs;
  assign unusedForwardInputs = ^{ex.memWbRegWrite, ex.memWbRd, ex.memWbData,
                                 ex.rs, ex.rt};
  assign operandA = ex.readData1;
  assign rtValue  = ex.readData2;
`endif

  assign operandB = rType ? rtValue : ex.immediateOperand;

  execute_alu u_alu (
    .op (aluOp),
    .a  (operandA),
    .b  (operandB),
    .y  (aluY)
  );

  // EX/MEM pipeline register; reset inserts a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex.result              <= '0;
      ex.writeData           <= '0;
      ex.rdOut               <= '0;
      ex.writeBackControlOut <= '0;
      ex.memAccessControlOut <= '0;
    end else begin
      ex.result              <= aluY;
      ex.writeData           <= rtValue;
      ex.rdOut               <= ex.rdIn;
      ex.writeBackControlOut <= ex.writeBackControlIn;
      ex.memAccessControlOut <= ex.memAccessControlIn;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: scoreboard of expected EX/MEM
// register contents from an independent reference model.
module tb_execute;
  import execute_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  execute_if bus ();

  execute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] writeData;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [1:0]  mem;
  } exp_t;

  exp_t sbQ[$];

  // Reference model output registers
  logic [31:0] mResult;
  logic [31:0] mWriteData;
  logic [4:0]  mRd;
  logic [1:0]  mWb;
  logic [1:0]  mMem;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelAlu(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      6'd0: return a + b;
      6'd1: return a - b;
      6'd2: return a & b;
      6'd3: return a | b;
      6'd4: return a ^ b;
      6'd5: return ~(a | b);
      6'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd7: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] modelFwd(input logic [4:0] src, input logic [31:0] regVal);
`ifdef EXECUTE_FORWARD_EN
    if (mWb[1] && mRd == src && mRd != 5'd0) return mResult;
    if (bus.memWbRegWrite && bus.memWbRd == src && bus.memWbRd != 5'd0) return bus.memWbData;
`endif
    return regVal;
  endfunction

  task automatic modelReset();
    mResult = '0; mWriteData = '0; mRd = '0; mWb = '0; mMem = '0;
  endtask

  task automatic checkOutputs(input string tag, input exp_t e);
    checkVal({tag, ".result"},    bus.result,                        e.result);
    checkVal({tag, ".writeData"}, bus.writeData,                     e.writeData);
    checkVal({tag, ".rdOut"},     {27'd0, bus.rdOut},                {27'd0, e.rd});
    checkVal({tag, ".wbOut"},     {30'd0, bus.writeBackControlOut},  {30'd0, e.wb});
    checkVal({tag, ".memOut"},    {30'd0, bus.memAccessControlOut},  {30'd0, e.mem});
  endtask

  // Drive one instruction, push its expected result, compare after the edge
  task automatic step(input string tag, input logic [1:0] wb, input logic [1:0] mem,
                      input logic [3:0] cc, input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rdIn, input logic mwW, input logic [4:0] mwRd,
                      input logic [31:0] mwData);
    exp_t e;
    logic [31:0] a, rtv, b;
    logic [5:0]  op;
    @(negedge clk);
    bus.writeBackControlIn = wb;
    bus.memAccessControlIn = mem;
    bus.calculationControl = cc;
    bus.readData1 = rd1;
    bus.readData2 = rd2;
    bus.immediateOperand = imm;
    bus.rs = rs;
    bus.rt = rt;
    bus.rdIn = rdIn;
    bus.memWbRegWrite = mwW;
    bus.memWbRd = mwRd;
    bus.memWbData = mwData;
    a   = modelFwd(rs, rd1);
    rtv = modelFwd(rt, rd2);
    b   = cc[3] ? rtv : imm;
    op  = cc[3] ? imm[5:0] : {3'b000, cc[2:0]};
    e.result = modelAlu(op, a, b);
    e.writeData = rtv;
    e.rd = rdIn;
    e.wb = wb;
    e.mem = mem;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkVal({tag, ".sbEmpty"}, 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkOutputs(tag, e);
      mResult = e.result; mWriteData = e.writeData; mRd = e.rd; mWb = e.wb; mMem = e.mem;
    end
  endtask

  exp_t zeroExp;

  initial begin
    checks = 0;
    errors = 0;
    zeroExp = '0;
    modelReset();
    bus.writeBackControlIn = '0; bus.memAccessControlIn = '0; bus.calculationControl = '0;
    bus.readData1 = '0; bus.readData2 = '0; bus.immediateOperand = '0;
    bus.rs = '0; bus.rt = '0; bus.rdIn = '0;
    bus.memWbRegWrite = 1'b0; bus.memWbRd = '0; bus.memWbData = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutputs("reset", zeroExp);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type ADD 15 + 1
    step("rAdd", 2'b10, 2'b00, 4'b1000, 32'd15, 32'd1, 32'd0, 5'd0, 5'd1, 5'd0, 1'b0, 5'd0, 32'd0);
    checkVal("rAdd.const", bus.result, 32'd16);
    // MEM/WB forward of rt
    step("mwFwd", 2'b10, 2'b00, 4'b1000, 32'd15, 32'd1, 32'd0, 5'd0, 5'd1, 5'd0, 1'b1, 5'd1, 32'd255);
`ifdef EXECUTE_FORWARD_EN
    checkVal("mwFwd.const", bus.result, 32'd270);
    checkVal("mwFwd.wdConst", bus.writeData, 32'd255);
`else
    checkVal("mwFwd.const", bus.result, 32'd16);
`endif
    // Register 0 never forwarded (EX/MEM rd=0 regWrite=1, MEM/WB rd=0)
    step("reg0", 2'b10, 2'b00, 4'b1000, 32'd3, 32'd1, 32'd1, 5'd2, 5'd0, 5'd2, 1'b1, 5'd0, 32'd99);
    checkVal("reg0.const", bus.result, 32'd2);
    // EX/MEM priority over MEM/WB
    step("prod", 2'b10, 2'b01, 4'b0000, 32'd100, 32'd0, 32'd0, 5'd3, 5'd4, 5'd5, 1'b0, 5'd0, 32'd0);
    step("prio", 2'b10, 2'b00, 4'b1000, 32'd7, 32'd1, 32'd0, 5'd5, 5'd6, 5'd0, 1'b1, 5'd5, 32'd50);
`ifdef EXECUTE_FORWARD_EN
    checkVal("prio.const", bus.result, 32'd101);
`else
    checkVal("prio.const", bus.result, 32'd8);
`endif
    // Immediate XOR, signed SLT, SUB wrap
    step("xorI", 2'b11, 2'b10, 4'b0100, 32'h0000F0F0, 32'd0, 32'h00000FF0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    checkVal("xorI.const", bus.result, 32'h0000FF00);
    step("slt", 2'b10, 2'b00, 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd6, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    checkVal("slt.const", bus.result, 32'd1);
    step("subW", 2'b10, 2'b00, 4'b0001, 32'd0, 32'd0, 32'd1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    checkVal("subW.const", bus.result, 32'hFFFFFFFF);
    // NOR, pass-B and an undefined funct
    step("norR", 2'b00, 2'b00, 4'b1000, 32'h0F0F0000, 32'h000000FF, 32'd5, 5'd7, 5'd8, 5'd1, 1'b0, 5'd0, 32'd0);
    step("passB", 2'b00, 2'b00, 4'b0111, 32'd1, 32'd2, 32'h12345678, 5'd7, 5'd8, 5'd1, 1'b0, 5'd0, 32'd0);
    step("undef", 2'b10, 2'b00, 4'b1000, 32'd9, 32'd9, 32'd9, 5'd0, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0);

    // Randomised traffic with a small register set to hit forwarding paths
    for (int i = 0; i < 60; i++) begin
      logic [31:0] imm;
      imm = $urandom;
      if ($urandom_range(0, 1) == 1) imm[5:0] = 6'($urandom_range(0, 9));
      step("rand", 2'($urandom), 2'($urandom), 4'($urandom),
           (i % 4 == 0) ? 32'h80000000 : $urandom, $urandom, imm,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    end

    // Asynchronous reset mid-cycle with nonzero outputs
    step("preRst", 2'b11, 2'b11, 4'b1000, 32'd40, 32'd2, 32'd0, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutputs("rstAsync", zeroExp);
    @(posedge clk);
    #1;
    checkOutputs("rstHeld", zeroExp);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    #1;
    checkOutputs("rstRelease", zeroExp);
    step("postRst", 2'b10, 2'b01, 4'b0010, 32'hFFFF00FF, 32'd0, 32'h0F0F0F0F, 5'd0, 5'd0, 5'd4, 1'b0, 5'd0, 32'd0);
    checkVal("postRst.const", bus.result, 32'h0F0F000F);

    checkVal("sbDrained", sbQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
